// File: rtl/tmr_seu_scrubber_pkg.sv
// Shared definitions for the TMR SEU scrubber.
// Contents: scrubber FSM state encoding, outlier-copy codes, 1-bit majority helper.
// Optional feature macro used by the top: TMR_SCRUB_SELF_TMR_EN.
package tmr_seu_scrubber_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SCRUB  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // Outlier-copy codes reported on err_copy.
  localparam logic [1:0] ERR_COPY_MIXED = 2'd0;
  localparam logic [1:0] ERR_COPY_Q1    = 2'd1;
  localparam logic [1:0] ERR_COPY_Q2    = 2'd2;
  localparam logic [1:0] ERR_COPY_Q3    = 2'd3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_seu_scrubber_vote.sv
// tmr_vote_w: W-bit triple-copy majority voter with mismatch and outlier-copy report.
// Ports:
//   a, b, c  in  W   the three copies
//   v_c      out W   bitwise majority
//   mm_c     out W   bits where the copies are not all equal
//   copy_c   out 2   outlier copy (1/2/3) if every mismatched bit blames it, else 0
module tmr_vote_w
  import tmr_seu_scrubber_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] v_c,
  output logic [W-1:0] mm_c,
  output logic [1:0]   copy_c
);

  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [W-1:0] out_c;

  assign v_c  = (a & b) | (a & c) | (b & c);
  assign mm_c = (a ^ b) | (a ^ c);

  // A copy is the outlier on a mismatched bit when the other two agree.
  assign out_a = mm_c & ~(b ^ c);
  assign out_b = mm_c & ~(a ^ c);
  assign out_c = mm_c & ~(a ^ b);

  always_comb begin
    copy_c = ERR_COPY_MIXED;
    if (mm_c != '0) begin
      if (out_a == mm_c)      copy_c = ERR_COPY_Q1;
      else if (out_b == mm_c) copy_c = ERR_COPY_Q2;
      else if (out_c == mm_c) copy_c = ERR_COPY_Q3;
    end
  end

endmodule

// File: rtl/tmr_seu_scrubber.sv
// tmr_seu_scrubber: monitors a triplicated register bank, votes it, and scrubs
// the voted value back on disagreement; counts corrected upsets, raises irq,
// and latches a permanent fault when repeated scrubs fail.
// Ports:
//   c          in   clock, rising edge
//   r          in   synchronous active-high reset
//   en         in   monitoring enable, sampled in IDLE only
//   q1,q2,q3   in   the three register copies
//   v          out  combinational majority vote
//   scrub_en   out  one-cycle load strobe to all copies
//   scrub_d    out  voted value to load
//   err_mask   out  mismatched bits at capture
//   err_copy   out  outlier copy at capture (0 = mixed)
//   seu_cnt    out  saturating corrected-event count
//   irq        out  event interrupt, level until irq_ack
//   irq_ack    in   clears irq
//   irq_ovf    out  sticky: event while irq already set
//   fault      out  sticky permanent fault
//   busy       out  sequence in progress
// Optional: define TMR_SCRUB_SELF_TMR_EN to triplicate and vote the FSM state,
// retry counter and fault flag.
module tmr_seu_scrubber
  import tmr_seu_scrubber_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CW        = 8,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             c,
  input  logic             r,
  input  logic             en,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  input  logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] v,
  output logic             scrub_en,
  output logic [WIDTH-1:0] scrub_d,
  output logic [WIDTH-1:0] err_mask,
  output logic [1:0]       err_copy,
  output logic [CW-1:0]    seu_cnt,
  output logic             irq,
  input  logic             irq_ack,
  output logic             irq_ovf,
  output logic             fault,
  output logic             busy
);

  localparam int unsigned RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [WIDTH-1:0] mm;
  logic [1:0]       copy;

  state_t           state;
  state_t           state_nxt;
  logic [RW-1:0]    retry;
  logic [RW-1:0]    retry_nxt;
  logic [SW-1:0]    settle;
  logic [SW-1:0]    settle_nxt;
  logic             fault_nxt;
  logic             scrub_en_nxt;
  logic [WIDTH-1:0] scrub_d_nxt;
  logic [WIDTH-1:0] err_mask_nxt;
  logic [1:0]       err_copy_nxt;
  logic [CW-1:0]    seu_cnt_nxt;
  logic             irq_nxt;
  logic             irq_ovf_nxt;
  logic             busy_nxt;

  // Data-path voter on the monitored bank.
  tmr_vote_w #(.W(WIDTH)) u_vote (
    .a      (q1),
    .b      (q2),
    .c      (q3),
    .v_c    (v),
    .mm_c   (mm),
    .copy_c (copy)
  );

`ifdef TMR_SCRUB_SELF_TMR_EN
  // Triplicated control state; every copy is rewritten from the voted next value.
  (* syn_preserve = 1 *) logic [STATE_W-1:0] st_q0, st_q1, st_q2;
  (* syn_preserve = 1 *) logic [RW-1:0]      rt_q0, rt_q1, rt_q2;
  (* syn_preserve = 1 *) logic               f_q0, f_q1, f_q2;
  logic [STATE_W-1:0] st_v;
  logic [STATE_W-1:0] st_mm;
  logic [1:0]         st_copy;

  tmr_vote_w #(.W(STATE_W)) u_state_vote (
    .a      (st_q0),
    .b      (st_q1),
    .c      (st_q2),
    .v_c    (st_v),
    .mm_c   (st_mm),
    .copy_c (st_copy)
  );

  assign state = state_t'(st_v);
  assign retry = (rt_q0 & rt_q1) | (rt_q0 & rt_q2) | (rt_q1 & rt_q2);
  assign fault = maj3(f_q0, f_q1, f_q2);

  always_ff @(posedge c) begin
    if (r) begin
      st_q0 <= ST_IDLE;
      st_q1 <= ST_IDLE;
      st_q2 <= ST_IDLE;
      rt_q0 <= '0;
      rt_q1 <= '0;
      rt_q2 <= '0;
      f_q0  <= 1'b0;
      f_q1  <= 1'b0;
      f_q2  <= 1'b0;
    end else begin
      st_q0 <= state_nxt;
      st_q1 <= state_nxt;
      st_q2 <= state_nxt;
      rt_q0 <= retry_nxt;
      rt_q1 <= retry_nxt;
      rt_q2 <= retry_nxt;
      f_q0  <= fault_nxt;
      f_q1  <= fault_nxt;
      f_q2  <= fault_nxt;
    end
  end
`else
  // Single-copy control state.
  always_ff @(posedge c) begin
    if (r) begin
      state <= ST_IDLE;
      retry <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      retry <= retry_nxt;
      fault <= fault_nxt;
    end
  end
`endif

  // Datapath and status registers.
  always_ff @(posedge c) begin
    if (r) begin
      settle   <= '0;
      scrub_en <= 1'b0;
      scrub_d  <= '0;
      err_mask <= '0;
      err_copy <= ERR_COPY_MIXED;
      seu_cnt  <= '0;
      irq      <= 1'b0;
      irq_ovf  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      settle   <= settle_nxt;
      scrub_en <= scrub_en_nxt;
      scrub_d  <= scrub_d_nxt;
      err_mask <= err_mask_nxt;
      err_copy <= err_copy_nxt;
      seu_cnt  <= seu_cnt_nxt;
      irq      <= irq_nxt;
      irq_ovf  <= irq_ovf_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state and next-output logic. scrub_en is registered on entry to SCRUB
  // so the strobe is high exactly while the FSM sits in SCRUB.
  always_comb begin
    state_nxt    = state;
    retry_nxt    = retry;
    settle_nxt   = settle;
    fault_nxt    = fault;
    scrub_en_nxt = 1'b0;
    scrub_d_nxt  = scrub_d;
    err_mask_nxt = err_mask;
    err_copy_nxt = err_copy;
    seu_cnt_nxt  = seu_cnt;
    irq_nxt      = irq_ack ? 1'b0 : irq;
    irq_ovf_nxt  = irq_ovf;

    unique case (state)
      ST_IDLE: begin
        if (en && (mm != '0)) begin
          err_mask_nxt = mm;
          err_copy_nxt = copy;
          scrub_d_nxt  = v;
          retry_nxt    = '0;
          scrub_en_nxt = 1'b1;
          state_nxt    = ST_SCRUB;
        end
      end
      ST_SCRUB: begin
        settle_nxt = '0;
        state_nxt  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle == SW'(SETTLE - 1)) state_nxt = ST_CHECK;
        else                           settle_nxt = settle + SW'(1);
      end
      ST_CHECK: begin
        if (mm == '0) begin
          if (seu_cnt != '1) seu_cnt_nxt = seu_cnt + CW'(1);
          // A set coinciding with an ack wins and is not an overflow.
          if (irq && !irq_ack) irq_ovf_nxt = 1'b1;
          irq_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else if ((32'(retry) + 32'd1) < MAX_RETRY) begin
          retry_nxt    = retry + RW'(1);
          scrub_d_nxt  = v;
          scrub_en_nxt = 1'b1;
          state_nxt    = ST_SCRUB;
        end else begin
          fault_nxt = 1'b1;
          state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
  end

endmodule

// File: tb/tb_tmr_seu_scrubber.sv
// Self-checking bench for tmr_seu_scrubber: emulates the TMR bank (loads on
// scrub_en, optional stuck copy), runs directed scenarios and a random phase,
// and compares every cycle against a timeline-based behavioural model.
module tb_tmr_seu_scrubber;

  localparam int unsigned SETTLE    = 2;
  localparam int unsigned MAX_RETRY = 3;

  logic       c = 1'b0;
  logic       r, en, irq_ack;
  logic [7:0] q1, q2, q3;
  logic [7:0] v, scrub_d, err_mask;
  logic [1:0] err_copy;
  logic [7:0] seu_cnt;
  logic       scrub_en, irq, irq_ovf, fault, busy;

  logic [7:0] v2, scrub_d2, err_mask2;
  logic [1:0] err_copy2;
  logic [1:0] seu_cnt2;
  logic       scrub_en2, irq2, irq_ovf2, fault2, busy2;

  tmr_seu_scrubber #(.WIDTH(8), .CW(8), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut (
    .c(c), .r(r), .en(en), .q1(q1), .q2(q2), .q3(q3), .v(v),
    .scrub_en(scrub_en), .scrub_d(scrub_d), .err_mask(err_mask), .err_copy(err_copy),
    .seu_cnt(seu_cnt), .irq(irq), .irq_ack(irq_ack), .irq_ovf(irq_ovf),
    .fault(fault), .busy(busy)
  );

  tmr_seu_scrubber #(.WIDTH(8), .CW(2), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut2 (
    .c(c), .r(r), .en(en), .q1(q1), .q2(q2), .q3(q3), .v(v2),
    .scrub_en(scrub_en2), .scrub_d(scrub_d2), .err_mask(err_mask2), .err_copy(err_copy2),
    .seu_cnt(seu_cnt2), .irq(irq2), .irq_ack(irq_ack), .irq_ovf(irq_ovf2),
    .fault(fault2), .busy(busy2)
  );

  always #5 c = ~c;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference helpers ----------------
  function automatic logic [7:0] f_maj(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(d[i]);
      m[i] = (ones >= 2);
    end
    return m;
  endfunction

  function automatic logic [7:0] f_mm(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = !((a[i] == b[i]) && (b[i] == d[i]));
    return m;
  endfunction

  function automatic logic [1:0] f_copy(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    int  who;
    bit  mixed;
    who   = 0;
    mixed = 0;
    for (int i = 0; i < 8; i++) begin
      if (!((a[i] == b[i]) && (b[i] == d[i]))) begin
        int k;
        if (b[i] == d[i])      k = 1;
        else if (a[i] == d[i]) k = 2;
        else                   k = 3;
        if (who == 0) who = k;
        else if (who != k) mixed = 1;
      end
    end
    return mixed ? 2'd0 : 2'(who);
  endfunction

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  // ---------------- behavioural model ----------------
  // m_k counts cycles since the most recent scrub strobe; recheck happens SETTLE+1 later.
  bit         m_active, m_fault, m_irq, m_ovf;
  int         m_k, m_att, m_cnt;
  logic [7:0] m_sd, m_em;
  logic [1:0] m_ec;

  always @(posedge c) begin
    logic [7:0] mmv;
    bit         pass_evt;
    if (r) begin
      m_active = 0; m_fault = 0; m_irq = 0; m_ovf = 0;
      m_k = 0; m_att = 0; m_cnt = 0;
      m_sd = 8'h00; m_em = 8'h00; m_ec = 2'd0;
    end else begin
      mmv      = f_mm(q1, q2, q3);
      pass_evt = 0;
      if (m_fault) begin
        pass_evt = 0;
      end else if (!m_active) begin
        if (en && (mmv != 8'h00)) begin
          m_active = 1; m_k = 0; m_att = 0;
          m_em = mmv; m_ec = f_copy(q1, q2, q3); m_sd = f_maj(q1, q2, q3);
        end
      end else if (m_k == int'(SETTLE) + 1) begin
        if (mmv == 8'h00) begin
          pass_evt = 1; m_active = 0;
        end else if (m_att + 1 < int'(MAX_RETRY)) begin
          m_att++; m_k = 0; m_sd = f_maj(q1, q2, q3);
        end else begin
          m_fault = 1; m_active = 0;
        end
      end else begin
        m_k++;
      end
      if (pass_evt) begin
        m_cnt++;
        if (m_irq && !irq_ack) m_ovf = 1;
        m_irq = 1;
      end else if (irq_ack) begin
        m_irq = 0;
      end
    end
  end

  bit checking = 0;

  always @(negedge c) begin
    if (checking) begin
      chk("v",        32'(v),        32'(f_maj(q1, q2, q3)));
      chk("scrub_en", 32'(scrub_en), 32'(m_active && (m_k == 0)));
      chk("scrub_d",  32'(scrub_d),  32'(m_sd));
      chk("err_mask", 32'(err_mask), 32'(m_em));
      chk("err_copy", 32'(err_copy), 32'(m_ec));
      chk("seu_cnt",  32'(seu_cnt),  32'(sat(m_cnt, 255)));
      chk("seu_cnt2", 32'(seu_cnt2), 32'(sat(m_cnt, 3)));
      chk("irq",      32'(irq),      32'(m_irq));
      chk("irq_ovf",  32'(irq_ovf),  32'(m_ovf));
      chk("fault",    32'(fault),    32'(m_fault));
      chk("busy",     32'(busy),     32'(m_active));
    end
  end

  // ---------------- bank emulation ----------------
  logic [7:0] b1, b2, b3;
  bit         stuck3;
  bit         ld;
  logic [7:0] ld_d;
  int         n_scrub;

  task automatic drive();
    q1 = b1;
    q2 = b2;
    q3 = stuck3 ? 8'hFF : b3;
  endtask

  // Advance one clock; the bank reloads if the strobe was high in the ended cycle.
  task automatic step();
    @(negedge c);
    ld   = scrub_en;
    ld_d = scrub_d;
    @(posedge c);
    #1;
    if (ld) begin b1 = ld_d; b2 = ld_d; b3 = ld_d; end
    drive();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    r = 1'b1; en = 1'b0; irq_ack = 1'b0; stuck3 = 0;
    b1 = 8'h00; b2 = 8'h00; b3 = 8'h00;
    drive();
    step();
    checking = 1;
    step();
    chk("rst_scrub_en", 32'(scrub_en), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_seu",      32'(seu_cnt),  32'd0);
    r = 1'b0;

    // Clean bank
    b1 = 8'hA5; b2 = 8'hA5; b3 = 8'hA5; en = 1'b1; drive();
    n_scrub = 0;
    repeat (50) begin step(); if (scrub_en) n_scrub++; end
    chk("clean_scrubs", 32'(n_scrub), 32'd0);
    chk("clean_v",      32'(v),       32'hA5);
    chk("clean_irq",    32'(irq),     32'd0);

    // Single upset on copy 2
    b2 = 8'hA4; drive();
    step();
    chk("single_scrub_en", 32'(scrub_en), 32'd1);
    chk("single_scrub_d",  32'(scrub_d),  32'hA5);
    chk("single_mask",     32'(err_mask), 32'h01);
    chk("single_copy",     32'(err_copy), 32'd2);
    repeat (3) step();
    chk("single_busy_chk", 32'(busy),    32'd1);
    chk("single_seu_pre",  32'(seu_cnt), 32'd0);
    step();
    chk("single_seu",  32'(seu_cnt), 32'd1);
    chk("single_irq",  32'(irq),     32'd1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("single_ack",  32'(irq),     32'd0);

    // Mixed upset on a zero bank
    b1 = 8'h01; b2 = 8'h00; b3 = 8'h80; drive();
    step();
    chk("mixed_mask",    32'(err_mask), 32'h81);
    chk("mixed_copy",    32'(err_copy), 32'd0);
    chk("mixed_scrub_d", 32'(scrub_d),  32'h00);
    repeat (5) step();
    chk("mixed_seu", 32'(seu_cnt), 32'd2);
    chk("mixed_ovf", 32'(irq_ovf), 32'd0);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;

    // Stuck copy 3 -> three scrubs then permanent fault
    stuck3 = 1; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00; drive();
    n_scrub = 0;
    repeat (20) begin step(); if (scrub_en) n_scrub++; end
    chk("stuck_scrubs", 32'(n_scrub), 32'd3);
    chk("stuck_fault",  32'(fault),   32'd1);
    chk("stuck_busy",   32'(busy),    32'd0);
    chk("stuck_seu",    32'(seu_cnt), 32'd2);
    n_scrub = 0;
    repeat (10) begin b1 = 8'($urandom); drive(); step(); if (scrub_en) n_scrub++; end
    chk("fault_no_scrub", 32'(n_scrub), 32'd0);
    chk("fault_v",        32'(v),       32'(f_maj(q1, q2, q3)));
    r = 1'b1; step(); r = 1'b0;
    chk("fault_rst", 32'(fault), 32'd0);
    stuck3 = 0; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00; drive();
    step();

    // Interrupt overflow and counter saturation
    repeat (2) begin b2 = b2 ^ 8'h10; drive(); repeat (6) step(); end
    chk("ovf_irq", 32'(irq),     32'd1);
    chk("ovf_ovf", 32'(irq_ovf), 32'd1);
    chk("ovf_seu", 32'(seu_cnt), 32'd2);
    repeat (3) begin b3 = b3 ^ 8'h04; drive(); repeat (6) step(); end
    chk("five_seu",     32'(seu_cnt),  32'd5);
    chk("five_seu_cw2", 32'(seu_cnt2), 32'd3);

    // Reset during SETTLE
    b2 = b2 ^ 8'h01; drive();
    step(); step(); step();
    r = 1'b1; step();
    chk("rstmid_scrub_en", 32'(scrub_en), 32'd0);
    chk("rstmid_busy",     32'(busy),     32'd0);
    chk("rstmid_scrub_d",  32'(scrub_d),  32'd0);
    chk("rstmid_irq_ovf",  32'(irq_ovf),  32'd0);
    chk("rstmid_seu",      32'(seu_cnt),  32'd0);
    r = 1'b0;
    n_scrub = 0;
    repeat (8) begin step(); if (scrub_en) n_scrub++; end
    chk("rstmid_no_repulse", 32'(n_scrub), 32'd0);

    // Random phase
    repeat (3000) begin
      en      = ($urandom % 10) != 0;
      irq_ack = ($urandom % 6) == 0;
      r       = ($urandom % 500) == 0;
      if (($urandom % 300) == 0) stuck3 = !stuck3;
      if (($urandom % 10) == 0) begin
        logic [7:0] fm;
        fm = 8'h01 << ($urandom % 8);
        case ($urandom % 3)
          0:       b1 = b1 ^ fm;
          1:       b2 = b2 ^ fm;
          default: b3 = b3 ^ fm;
        endcase
      end
      drive();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
